// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: processor port (C) has fixed priority over the NIC DMA port (N),
// with a NIC starvation guard and bounded NIC bursts. Define DMEM_ARB_STATS_EN for stat counters.
module dmem_arbiter #(
    parameter int MAX_WAIT  = 4,
    parameter int NIC_BURST = 4,
    parameter int AW        = 32,
    parameter int DW        = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_en,
    input  logic          cpu_wr_en,
    input  logic [0:AW-1] cpu_addr,
    input  logic [0:DW-1] cpu_wdata,
    output logic [0:DW-1] cpu_rdata,
    output logic          cpu_stall,
    input  logic          nic_req,
    input  logic          nic_wr_en,
    input  logic [0:AW-1] nic_addr,
    input  logic [0:DW-1] nic_wdata,
    output logic          nic_gnt,
    output logic [0:DW-1] nic_rdata,
    output logic          nic_rvalid,
    output logic          mem_en,
    output logic          mem_wr_en,
    output logic [0:AW-1] mem_addr,
    output logic [0:DW-1] mem_wdata,
    input  logic [0:DW-1] mem_rdata,
    output logic          dbg_state,
    output logic [1:0]    dbg_rd_owner
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]   stat_conflicts,
    output logic [15:0]   stat_stalls
`endif
);

    // Handshake: nic_req (with its address/data) is held until nic_gnt is seen in the same
    // cycle; the CPU holds cpu_en and its operands for every cycle cpu_stall is high.
    typedef enum logic { C_PRI = 1'b0, N_BURST = 1'b1 } state_t;
    typedef enum logic [1:0] { OWN_NONE = 2'd0, OWN_C = 2'd1, OWN_N = 2'd2 } owner_t;

    localparam logic [3:0] MAX_WAIT_L  = 4'(MAX_WAIT);
    localparam logic [3:0] NIC_BURST_L = 4'(NIC_BURST);

    state_t     state;
    owner_t     rd_owner;
    logic [3:0] wait_cnt;
    logic [3:0] burst_cnt;
    logic [3:0] burst_next;
    logic       nic_rvalid_q;
    logic       c_win;
    logic       n_win;

    always_comb begin
        c_win = 1'b0;
        n_win = 1'b0;
        if (!reset) begin
            if (state == N_BURST) begin
                if (nic_req) n_win = 1'b1;
                else         c_win = cpu_en;
            end else begin
                if (nic_req && (!cpu_en || wait_cnt >= MAX_WAIT_L)) n_win = 1'b1;
                else                                               c_win = cpu_en;
            end
        end
    end

    assign burst_next = burst_cnt + 4'd1;

    assign mem_en       = c_win | n_win;
    assign mem_wr_en    = (c_win & cpu_wr_en) | (n_win & nic_wr_en);
    assign mem_addr     = n_win ? nic_addr  : cpu_addr;
    assign mem_wdata    = n_win ? nic_wdata : cpu_wdata;
    assign nic_gnt      = n_win;
    assign cpu_stall    = cpu_en & n_win;
    assign cpu_rdata    = mem_rdata;
    assign nic_rdata    = mem_rdata;
    assign dbg_state    = state;
    assign dbg_rd_owner = rd_owner;

    // A read still in flight when reset rises is dropped rather than reported.
    assign nic_rvalid = nic_rvalid_q & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= C_PRI;
            wait_cnt     <= 4'd0;
            burst_cnt    <= 4'd0;
            nic_rvalid_q <= 1'b0;
            rd_owner     <= OWN_NONE;
        end else begin
            nic_rvalid_q <= n_win & ~nic_wr_en;
            if (n_win && !nic_wr_en)      rd_owner <= OWN_N;
            else if (c_win && !cpu_wr_en) rd_owner <= OWN_C;
            else                          rd_owner <= OWN_NONE;

            case (state)
                C_PRI: begin
                    if (n_win) begin
                        wait_cnt <= 4'd0;
                        // N winning while the CPU requests is the forced grant: first of the burst.
                        if (cpu_en) begin
                            if (NIC_BURST_L > 4'd1) begin
                                state     <= N_BURST;
                                burst_cnt <= 4'd1;
                            end else begin
                                burst_cnt <= 4'd0;
                            end
                        end
                    end else if (cpu_en && nic_req) begin
                        wait_cnt <= (wait_cnt == 4'd15) ? 4'd15 : wait_cnt + 4'd1;
                    end
                end
                N_BURST: begin
                    if (n_win) begin
                        if (burst_next >= NIC_BURST_L) begin
                            state     <= C_PRI;
                            burst_cnt <= 4'd0;
                        end else begin
                            burst_cnt <= burst_next;
                        end
                    end else begin
                        state     <= C_PRI;
                        burst_cnt <= 4'd0;
                    end
                end
                default: state <= C_PRI;
            endcase
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_conflicts <= 16'd0;
            stat_stalls    <= 16'd0;
        end else begin
            if (cpu_en && nic_req && stat_conflicts != 16'hFFFF)
                stat_conflicts <= stat_conflicts + 16'd1;
            if (cpu_stall && stat_stalls != 16'hFFFF)
                stat_stalls <= stat_stalls + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small 1-cycle-latency dmem model.
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam logic [63:0] D1 = 64'hDEADBEEF_00000001;
    localparam logic [63:0] P3 = 64'h0123456789ABCDEF;
    localparam logic [63:0] W5 = 64'hA5A5_0000_5A5A_1111;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_en, cpu_wr_en, nic_req, nic_wr_en;
    logic [0:AW-1] cpu_addr, nic_addr, mem_addr;
    logic [0:DW-1] cpu_wdata, nic_wdata, mem_wdata, mem_rdata, cpu_rdata, nic_rdata;
    logic          cpu_stall, nic_gnt, nic_rvalid, mem_en, mem_wr_en, dbg_state;
    logic [1:0]    dbg_rd_owner;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0]   stat_conflicts, stat_stalls;
`endif

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] dmem [0:15];

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_en(cpu_en), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .nic_req(nic_req), .nic_wr_en(nic_wr_en), .nic_addr(nic_addr), .nic_wdata(nic_wdata),
        .nic_gnt(nic_gnt), .nic_rdata(nic_rdata), .nic_rvalid(nic_rvalid),
        .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dbg_state(dbg_state), .dbg_rd_owner(dbg_rd_owner)
`ifdef DMEM_ARB_STATS_EN
        , .stat_conflicts(stat_conflicts), .stat_stalls(stat_stalls)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    // dmem model: word 3 preloaded while reset is high
    always @(posedge clk) begin
        if (reset) begin
            dmem[3] <= P3;
        end else if (mem_en) begin
            if (mem_wr_en) dmem[mem_addr[AW-4:AW-1]] <= mem_wdata;
            else           mem_rdata <= dmem[mem_addr[AW-4:AW-1]];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // drive one cycle of inputs at the falling edge; outputs settle 1 time unit later
    task automatic drive(input logic r, input logic c_en, input logic c_wr,
                         input logic [31:0] c_addr, input logic [63:0] c_wd,
                         input logic n_req, input logic n_wr,
                         input logic [31:0] n_addr, input logic [63:0] n_wd);
        @(negedge clk);
        reset     = r;
        cpu_en    = c_en;
        cpu_wr_en = c_wr;
        cpu_addr  = c_addr;
        cpu_wdata = c_wd;
        nic_req   = n_req;
        nic_wr_en = n_wr;
        nic_addr  = n_addr;
        nic_wdata = n_wd;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 64'd0, 1'b0, 1'b0, 32'd0, 64'd0);
    endtask

    task automatic both(input logic r);
        drive(r, 1'b1, 1'b0, 32'd8, 64'd0, 1'b1, 1'b0, 32'd3, 64'd0);
    endtask

    initial begin
        logic exp_n;
        logic prev_n;
        reset = 1'b1;
        cpu_en = 1'b0; cpu_wr_en = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        nic_req = 1'b0; nic_wr_en = 1'b0; nic_addr = '0; nic_wdata = '0;

        // reset: grants forced low even with both requesting
        both(1'b1);
        both(1'b1);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_mem_wr_en", 64'(mem_wr_en), 64'd0);
        check("rst_nic_gnt", 64'(nic_gnt), 64'd0);
        check("rst_cpu_stall", 64'(cpu_stall), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        check("rst_nic_rvalid", 64'(nic_rvalid), 64'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 64'd0, 1'b0, 1'b0, 32'd0, 64'd0);

        // CPU only: write then read back
        drive(1'b0, 1'b1, 1'b1, 32'd8, D1, 1'b0, 1'b0, 32'd0, 64'd0);
        check("cpu_wr_mem_en", 64'(mem_en), 64'd1);
        check("cpu_wr_mem_wr_en", 64'(mem_wr_en), 64'd1);
        check("cpu_wr_addr", 64'(mem_addr), 64'd8);
        check("cpu_wr_wdata", mem_wdata, D1);
        check("cpu_wr_stall", 64'(cpu_stall), 64'd0);
        check("cpu_wr_nic_gnt", 64'(nic_gnt), 64'd0);
        drive(1'b0, 1'b1, 1'b0, 32'd8, 64'd0, 1'b0, 1'b0, 32'd0, 64'd0);
        check("cpu_rd_mem_en", 64'(mem_en), 64'd1);
        check("cpu_rd_mem_wr_en", 64'(mem_wr_en), 64'd0);
        check("cpu_rd_stall", 64'(cpu_stall), 64'd0);
        idle();
        check("cpu_rdata", cpu_rdata, D1);
        check("cpu_rd_owner", 64'(dbg_rd_owner), 64'd1);
        check("cpu_nic_rvalid", 64'(nic_rvalid), 64'd0);
        check("idle_mem_en", 64'(mem_en), 64'd0);

        // NIC only: read preloaded word, then write and read back through the CPU
        drive(1'b0, 1'b0, 1'b0, 32'd0, 64'd0, 1'b1, 1'b0, 32'd3, 64'd0);
        check("nic_rd_gnt", 64'(nic_gnt), 64'd1);
        check("nic_rd_addr", 64'(mem_addr), 64'd3);
        check("nic_rd_wr_en", 64'(mem_wr_en), 64'd0);
        check("nic_rd_stall", 64'(cpu_stall), 64'd0);
        exp_q.push_back(P3);
        idle();
        check("nic_rvalid", 64'(nic_rvalid), 64'd1);
        check("nic_rd_owner", 64'(dbg_rd_owner), 64'd2);
        if (exp_q.size() > 0) check("nic_rdata", nic_rdata, exp_q.pop_front());
        idle();
        check("nic_rvalid_drop", 64'(nic_rvalid), 64'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 64'd0, 1'b1, 1'b1, 32'd5, W5);
        check("nic_wr_gnt", 64'(nic_gnt), 64'd1);
        check("nic_wr_wr_en", 64'(mem_wr_en), 64'd1);
        check("nic_wr_wdata", mem_wdata, W5);
        drive(1'b0, 1'b1, 1'b0, 32'd5, 64'd0, 1'b0, 1'b0, 32'd0, 64'd0);
        check("nic_wr_no_rvalid", 64'(nic_rvalid), 64'd0);
        idle();
        check("nic_wr_readback", cpu_rdata, W5);

        // starvation: 4 C wins, 4 N wins with stall, repeating
        prev_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            both(1'b0);
            exp_n = ((i / 4) % 2) == 1;
            check($sformatf("starve_gnt[%0d]", i), 64'(nic_gnt), 64'(exp_n));
            check($sformatf("starve_stall[%0d]", i), 64'(cpu_stall), 64'(exp_n));
            check($sformatf("starve_mem_en[%0d]", i), 64'(mem_en), 64'd1);
            if (i > 0) check($sformatf("starve_rvalid[%0d]", i), 64'(nic_rvalid), 64'(prev_n));
            if (prev_n) check($sformatf("starve_rdata[%0d]", i), nic_rdata, P3);
            prev_n = exp_n;
        end
        idle();
        check("starve_last_rvalid", 64'(nic_rvalid), 64'd1);
        check("starve_end_state", 64'(dbg_state), 64'd0);
`ifdef DMEM_ARB_STATS_EN
        check("stat_conflicts", 64'(stat_conflicts), 64'd16);
        check("stat_stalls", 64'(stat_stalls), 64'd8);
`endif

        // burst cut short after 2 NIC grants
        for (int i = 0; i < 4; i++) begin
            both(1'b0);
            check($sformatf("cut_c_win[%0d]", i), 64'(nic_gnt), 64'd0);
        end
        both(1'b0);
        check("cut_forced_gnt", 64'(nic_gnt), 64'd1);
        check("cut_forced_stall", 64'(cpu_stall), 64'd1);
        both(1'b0);
        check("cut_burst_state", 64'(dbg_state), 64'd1);
        check("cut_burst_gnt", 64'(nic_gnt), 64'd1);
        drive(1'b0, 1'b1, 1'b0, 32'd8, 64'd0, 1'b0, 1'b0, 32'd3, 64'd0);
        check("cut_c_gnt", 64'(nic_gnt), 64'd0);
        check("cut_c_stall", 64'(cpu_stall), 64'd0);
        check("cut_c_mem_en", 64'(mem_en), 64'd1);
        check("cut_c_addr", 64'(mem_addr), 64'd8);
        idle();
        check("cut_state_back", 64'(dbg_state), 64'd0);

        // reset during the 2nd burst grant of a NIC read
        for (int i = 0; i < 4; i++) both(1'b0);
        both(1'b0);
        check("rmb_forced_gnt", 64'(nic_gnt), 64'd1);
        both(1'b1);
        check("rmb_rst_gnt", 64'(nic_gnt), 64'd0);
        check("rmb_rst_mem_en", 64'(mem_en), 64'd0);
        check("rmb_rst_stall", 64'(cpu_stall), 64'd0);
        check("rmb_rst_rvalid", 64'(nic_rvalid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            both(1'b0);
            check($sformatf("rmb_c_win[%0d]", i), 64'(nic_gnt), 64'd0);
            check($sformatf("rmb_c_stall[%0d]", i), 64'(cpu_stall), 64'd0);
            if (i == 0) check("rmb_no_rvalid", 64'(nic_rvalid), 64'd0);
        end
        both(1'b0);
        check("rmb_n_win", 64'(nic_gnt), 64'd1);
        check("rmb_n_stall", 64'(cpu_stall), 64'd1);
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
